// File: rtl/vga_apb4_mst.sv
// vga_apb4_mst - APB4 initiator issuing single read/write transfers.
//
// A requester hands one command at a time over a valid/ready channel. The
// block runs one APB4 transfer (SETUP, then ACCESS until pready or timeout)
// and returns the result over a valid/ready response channel. Only one
// transaction is in flight; a new command is taken only from IDLE.
//
// Ports:
//   pclk_i, rst_i            clock, synchronous active-high reset
//   cmd_*                    command channel (valid/ready, write, addr,
//                            wdata, strb, prot)
//   tmo_cyc_i                max ACCESS cycles before abort, 0 = no timeout
//   rsp_*                    response channel (valid/ready, rdata, err, tmo)
//   busy_o                   transaction in progress
//   p*_o / p*_i              APB4 requester-side bus signals
module vga_apb4_mst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                    pclk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  input  logic [2:0]              cmd_prot_i,
  input  logic [TMO_WIDTH-1:0]    tmo_cyc_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tmo_o,
  output logic                    busy_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    pwrite_q, pwrite_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    tmo_q, tmo_d;
  logic [TMO_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    tmo_fire;

  // Counter holds at all-ones so a long wait with the timeout disabled
  // cannot wrap around into a spurious match if tmo_cyc_i is raised later.
  function automatic logic [TMO_WIDTH-1:0] sat_inc(input logic [TMO_WIDTH-1:0] v);
    if (&v) return v;
    return v + TMO_ONE;
  endfunction

  // Counter counts completed ACCESS cycles without pready; this cycle is
  // the tmo_cyc_i-th one when the count equals tmo_cyc_i-1.
  assign tmo_fire = (tmo_cyc_i != '0) && (cnt_q == (tmo_cyc_i - TMO_ONE));

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_wdata_i;
          pstrb_d  = cmd_write_i ? cmd_strb_i : '0;
          pprot_d  = cmd_prot_i;
          pwrite_d = cmd_write_i;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // pready has priority over a timeout firing in the same cycle.
        if (pready_i) begin
          rdata_d   = pwrite_q ? '0 : prdata_i;
          err_d     = pslverr_i;
          tmo_d     = 1'b0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = S_RESP;
        end else if (tmo_fire) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          tmo_d     = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign rsp_tmo_o   = tmo_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign pprot_o     = pprot_q;
  assign pwrite_o    = pwrite_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;

endmodule
